// File: rtl/i2c_pkg.sv
// i2c_pkg: shared sequencer state encoding and command word layout.
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, RECOVER} state_t;
    localparam int CMD_W    = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_W   = 7;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 8;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous command FIFO; pointers carry an extra wrap bit
// so full and empty are distinguishable without a counter.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [CMD_W-1:0] i_wdata,
    input  logic             i_pop,
    output logic [CMD_W-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CMD_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: buffers host I2C commands and issues them one at a time to
// i2c_master, returning one response (read data or timeout) per command.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_rw,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       m_start,
    output logic       m_read_write,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_data_in,
    input  logic [7:0] m_data_out,
    input  logic       m_busy,
    input  logic       m_done
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t           r_state, w_state;
    logic             r_busy_m, r_busy_s, r_done_m, r_done_s;
    logic [TW-1:0]    r_timer, w_timer;
    logic             r_m_start, w_m_start, r_m_rw, w_m_rw;
    logic [6:0]       r_m_addr, w_m_addr;
    logic [7:0]       r_m_data, w_m_data;
    logic             r_rsp_valid, w_rsp_valid, r_rsp_rw, w_rsp_rw;
    logic             r_rsp_timeout, w_rsp_timeout;
    logic [7:0]       r_rsp_rdata, w_rsp_rdata;
    logic             w_full, w_empty, w_pop, w_expire, w_to;
    logic [CMD_W-1:0] w_cmd;

    i2c_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (cmd_valid && !w_full),
        .i_wdata({cmd_rw, cmd_addr, cmd_wdata}),
        .i_pop  (w_pop),
        .o_rdata(w_cmd),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    assign cmd_ready    = !w_full;
    assign w_expire     = r_timer == TW'(TIMEOUT_CYCLES);
    assign m_start      = r_m_start;
    assign m_read_write = r_m_rw;
    assign m_slave_addr = r_m_addr;
    assign m_data_in    = r_m_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rw       = r_rsp_rw;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_timeout  = r_rsp_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
            r_done_m <= 1'b0;
            r_done_s <= 1'b0;
        end else begin
            r_busy_m <= m_busy;
            r_busy_s <= r_busy_m;
            r_done_m <= m_done;
            r_done_s <= r_done_m;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_timer       = r_timer;
        w_pop         = 1'b0;
        w_to          = 1'b0;
        w_m_start     = r_m_start;
        w_m_rw        = r_m_rw;
        w_m_addr      = r_m_addr;
        w_m_data      = r_m_data;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rw      = r_rsp_rw;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_timeout = r_rsp_timeout;
        case (r_state)
            IDLE: if (!w_empty && !r_busy_s) begin
                w_pop     = 1'b1;
                w_m_start = 1'b1;
                w_m_rw    = w_cmd[RW_BIT];
                w_m_addr  = w_cmd[ADDR_LSB +: ADDR_W];
                w_m_data  = w_cmd[DATA_LSB +: DATA_W];
                w_timer   = '0;
                w_state   = LAUNCH;
            end
            LAUNCH: begin
                w_timer = r_timer + 1'b1;
                if (w_expire) w_to = 1'b1;
                else if (r_busy_s) begin
                    w_m_start = 1'b0;
                    w_state   = WAIT;
                end
            end
            WAIT: begin
                w_timer = r_timer + 1'b1;
                if (r_done_s) begin
                    w_rsp_valid   = 1'b1;
                    w_rsp_rw      = r_m_rw;
                    w_rsp_rdata   = r_m_rw ? m_data_out : 8'h00;
                    w_rsp_timeout = 1'b0;
                    w_state       = RESP;
                end else if (w_expire) w_to = 1'b1;
            end
            RESP: if (rsp_ready) begin
                w_rsp_valid = 1'b0;
                w_state     = r_rsp_timeout ? RECOVER : IDLE;
            end
            RECOVER: if (!r_busy_s && !r_done_s) w_state = IDLE;
            default: w_state = IDLE;
        endcase
        // An abandoned command still yields a response so ordering is preserved
        if (w_to) begin
            w_m_start     = 1'b0;
            w_rsp_valid   = 1'b1;
            w_rsp_rw      = r_m_rw;
            w_rsp_rdata   = 8'h00;
            w_rsp_timeout = 1'b1;
            w_state       = RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_m_start     <= 1'b0;
            r_m_rw        <= 1'b0;
            r_m_addr      <= '0;
            r_m_data      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rw      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_timer       <= w_timer;
            r_m_start     <= w_m_start;
            r_m_rw        <= w_m_rw;
            r_m_addr      <= w_m_addr;
            r_m_data      <= w_m_data;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rw      <= w_rsp_rw;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command front-end for the 50 MHz I2C master. It buffers single-byte I2C read/write commands from a host-side valid/ready port in a small FIFO. It issues them one at a time to the master's start/busy/done interface and returns one response per command: read data, or a timeout flag. It sits directly upstream of `i2c_master`, drives its command inputs and consumes its `data_out`/`busy`/`done`.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 65535: `clk` cycles allowed in LAUNCH plus WAIT before the command is abandoned; ≥1024.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_rw`  in  1  1 = read, 0 = write.
- `cmd_addr`  in  7  slave address.
- `cmd_wdata`  in  8  write byte; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_rw`  out  1  echo of the command's `rw`.
- `rsp_rdata`  out  8  read byte; 0 for writes and timeouts.
- `rsp_timeout`  out  1  command abandoned.
- `m_start`  out  1  to master `start`.
- `m_read_write`  out  1  to master `read_write`.
- `m_slave_addr`  out  7  to master `slave_addr`.
- `m_data_in`  out  8  to master `data_in`.
- `m_data_out`  in  8  from master `data_out`.
- `m_busy`  in  1  from master `busy`.
- `m_done`  in  1  from master `done`.

## Operation
- **Master timing:** the master samples on `scl_int` rising edges, one every 500 `clk`. `m_busy` and `m_done` each pass through a 2-flop synchronizer (`busy_s`, `done_s`) before use.
- **FIFO:** a push occurs when `cmd_valid && cmd_ready`; one entry is {rw, addr, wdata}. `cmd_ready = !full`, registered-state derived. A push while full is impossible. A pop and a push in the same cycle are both performed.
- **IDLE:** if the FIFO is non-empty and `busy_s == 0`:
  - pop the entry;
  - load `m_read_write`, `m_slave_addr` and `m_data_in` from the entry;
  - hold those outputs stable until the next pop;
  - set `m_start = 1`, clear the timer, go to LAUNCH.
- **LAUNCH:** hold `m_start = 1` until `busy_s == 1`, then set `m_start = 0` and go to WAIT.
- **WAIT:** on `done_s == 1`:
  - capture `m_data_out` into `rsp_rdata` (reads) or load 0 (writes);
  - set `rsp_timeout = 0`, go to RESP.
  - The master holds `done` and `data_out` for a full `scl` period, so the synchronized sample is stable.
- **Timer:** counts every cycle in LAUNCH and WAIT. When it reaches `TIMEOUT_CYCLES`:
  - set `m_start = 0`, `rsp_rdata = 0`, `rsp_timeout = 1`;
  - go to RESP.
- **RESP:** assert `rsp_valid`, with `rsp_*` stable, until `rsp_ready`. On the cycle `rsp_valid && rsp_ready`:
  - go to RECOVER if the response was a timeout;
  - otherwise go to IDLE.
- **RECOVER:** wait for `busy_s == 0` and `done_s == 0`, then go to IDLE. This prevents a stale `done` from completing the next command.
- **Ordering:** responses come out in command order, exactly one per accepted command. There is no outstanding-command overlap.
- **Reset (asserted anywhere):**
  - FIFO is emptied and the state goes to IDLE.
  - `m_start`, `m_read_write`, `rsp_valid`, `rsp_rw`, `rsp_timeout` = 0.
  - `m_slave_addr`, `m_data_in`, `rsp_rdata` = 0.
  - `cmd_ready` = 1 after reset.
  - Any in-flight command is lost with no response.

## Timing
- **Launch latency:** a command is accepted at edge N. With the sequencer idle and the FIFO empty before N:
  - the FIFO shows non-empty after N;
  - the pop occurs at N+1;
  - `m_start` is high after edge N+1.
- **Start to busy:** `busy_s` rises 0–500 cycles after `m_start` (next `scl_int` edge), plus 2 sync cycles.
- **Transaction length:** a typical write is about 20 `scl` periods (≈10,000 `clk`) until `done_s`.
- **Response:** `rsp_valid` rises the cycle after the `done_s` rise, or after timer expiry.
- **Back-to-back:** IDLE re-evaluates the cycle after a handshake. The next `m_start` comes no earlier than 1 cycle after `rsp_valid && rsp_ready` when `busy_s == 0`.
- **Timer width:** `$clog2(TIMEOUT_CYCLES+1)` bits. The comparison is equality, so there is no wrap.

## Structure
- **Shared package `i2c_pkg`:**
  - state encoding constants: IDLE, LAUNCH, WAIT, RESP, RECOVER;
  - command word width (16 = 1 + 7 + 8);
  - field offsets.
- **Sub-module `i2c_cmd_fifo`:** synchronous FIFO, parameter DEPTH, width 16, outputs full/empty, pointers one bit wider than the index.
- **Top level:** the synchronizers, timer and FSM live in the top module.

## Test plan
- **Write:** push {rw=0, addr=0x50, wdata=0x3C} against an `i2c_master` model with an ACKing slave. Expect:
  - `m_slave_addr = 0x50`, `m_data_in = 0x3C`, `m_start` high until `busy` is seen;
  - one response with `rsp_rw = 0`, `rsp_rdata = 0x00`, `rsp_timeout = 0`.
- **Read:** the slave returns 0xA5. Expect `rsp_rw = 1`, `rsp_rdata = 0xA5`, `rsp_timeout = 0`.
- **Backpressure:** with `CMD_DEPTH = 4`, push 6 commands back-to-back while the first is in flight. Expect:
  - `cmd_ready` low after 4 entries are buffered (5 accepted including the in-flight one);
  - `cmd_ready` high again after a pop;
  - 6 responses in order.
- **Timeout:** `m_busy` tied to 0, `TIMEOUT_CYCLES = 1024`. Expect:
  - `m_start` drops and `rsp_valid` rises at cycle 1025 after `m_start` rises;
  - `rsp_timeout = 1`, `rsp_rdata = 0`;
  - the next command launches.
- **Response stall:** hold `rsp_ready = 0` for 2000 cycles after `rsp_valid`. Expect:
  - `rsp_*` stable throughout;
  - no new `m_start`;
  - after release, the next command launches 1 cycle later.
- **Reset in WAIT:** assert `rst_n = 0` mid-transaction. Expect:
  - all outputs at reset values immediately (asynchronously);
  - FIFO empty, no response emitted;
  - the command after reset completes normally.
